// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch PC sequencer: boot load, sequential stepping, trap/redirect
// steering, single-outstanding imem handshake and valid/ready handoff to decode.
module pc_fetch_sequencer #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32,
    parameter int unsigned INC  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] boot_addr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            halt,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc_out,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_REQ    = 2'd1,
        S_VALID  = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [ILEN-1:0] inst_data_q, inst_data_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            kill_q, kill_d;

    logic            redir;
    logic [XLEN-1:0] redir_sel;
    logic [XLEN-1:0] redir_tgt;

    // Trap beats redirect; targets are forced word-aligned.
    assign redir     = trap_valid | redirect_valid;
    assign redir_sel = trap_valid ? trap_target : redirect_target;
    assign redir_tgt = {redir_sel[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:   state_d = halt ? S_HALTED : S_REQ;
            S_REQ:    if (imem_ack && !kill_q && !redir) state_d = S_VALID;
            S_VALID:  if (redir || inst_ready) state_d = halt ? S_HALTED : S_REQ;
            S_HALTED: if (!redir && !halt) state_d = S_REQ;
            default:  state_d = S_BOOT;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == S_REQ);
        inst_valid = (state_q == S_VALID);
        halted     = (state_q == S_HALTED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= '0;
            pend_q      <= '0;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
            kill_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
            kill_q      <= kill_d;
        end
    end

    // A redirect seen while a request is outstanding is parked in pend_q and
    // applied when the ack retires the (discarded) word.
    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        kill_d      = kill_q;
        unique case (state_q)
            S_BOOT: pc_d = boot_addr;
            S_REQ: begin
                if (imem_ack) begin
                    if (kill_q || redir) begin
                        pc_d   = redir ? redir_tgt : pend_q;
                        kill_d = 1'b0;
                    end else begin
                        inst_data_d = imem_rdata;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + XLEN'(INC);
                    end
                end else if (redir) begin
                    kill_d = 1'b1;
                    pend_d = redir_tgt;
                end
            end
            S_VALID:  if (redir) pc_d = redir_tgt;
            S_HALTED: if (redir) pc_d = redir_tgt;
            default:  pc_d = pc_q;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign inst_data = inst_data_q;
    assign inst_pc   = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed plus randomized bench for pc_fetch_sequencer against a flag-based
// behavioural model of the fetch/handoff rules.
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] boot_addr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] pc_out;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: which phase the sequencer is in, plus the architectural values.
    bit          m_boot, m_req, m_valid, m_halted, m_kill;
    logic [31:0] m_pc, m_pend, m_idata, m_ipc;

    pc_fetch_sequencer #(.XLEN(32), .ILEN(32), .INC(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .boot_addr       (boot_addr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .halt            (halt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .pc_out          (pc_out),
        .halted          (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_boot = 1; m_req = 0; m_valid = 0; m_halted = 0; m_kill = 0;
        m_pc = 0; m_pend = 0; m_idata = 0; m_ipc = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        bit          jump;
        logic [31:0] tgt;
        jump = trap_valid || redirect_valid;
        tgt  = (trap_valid ? trap_target : redirect_target) & 32'hFFFF_FFFC;
        if (m_boot) begin
            m_pc = boot_addr;
            m_boot = 0;
            if (halt) m_halted = 1; else m_req = 1;
        end else if (m_req) begin
            if (imem_ack) begin
                if (m_kill || jump) begin
                    m_pc = jump ? tgt : m_pend;
                    m_kill = 0;
                end else begin
                    m_idata = imem_rdata;
                    m_ipc   = m_pc;
                    m_pc    = m_pc + 32'd4;
                    m_req   = 0;
                    m_valid = 1;
                end
            end else if (jump) begin
                m_kill = 1;
                m_pend = tgt;
            end
        end else if (m_valid) begin
            if (jump || inst_ready) begin
                if (jump) m_pc = tgt;
                m_valid = 0;
                if (halt) m_halted = 1; else m_req = 1;
            end
        end else if (m_halted) begin
            if (jump) m_pc = tgt;
            else if (!halt) begin
                m_halted = 0;
                m_req = 1;
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("imem_req",   32'(imem_req),   32'(m_req));
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("halted",     32'(halted),     32'(m_halted));
        chk("pc_out",     pc_out,          m_pc);
        chk("imem_addr",  imem_addr,       m_pc);
        chk("inst_data",  inst_data,       m_idata);
        chk("inst_pc",    inst_pc,         m_ipc);
    endtask

    task automatic clear_inputs();
        redirect_valid = 0; redirect_target = 0;
        trap_valid = 0; trap_target = 0;
        halt = 0; imem_ack = 0; imem_rdata = 0; inst_ready = 0;
    endtask

    // Called mid-cycle; releases reset before the next rising edge.
    task automatic do_reset(input logic [31:0] b);
        rst = 0;
        #1;
        model_reset();
        clear_inputs();
        boot_addr = b;
        #2;
        rst = 1;
    endtask

    initial begin
        logic [31:0] held_data, held_pc;
        rst = 0;
        boot_addr = 0;
        clear_inputs();
        model_reset();
        #12;
        chk("rst_req",    32'(imem_req),   32'd0);
        chk("rst_valid",  32'(inst_valid), 32'd0);
        chk("rst_halted", 32'(halted),     32'd0);
        chk("rst_pc",     pc_out,          32'd0);

        // Sequential fetch, zero-wait memory, decoder always ready.
        do_reset(32'h0000_1000);
        cyc();
        inst_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, 32'h1000 + 32'(i) * 32'd4);
            imem_ack = 1;
            imem_rdata = 32'h1111_0000 + 32'(i);
            cyc();
            imem_ack = 0;
            chk("seq_ipc", inst_pc, 32'h1000 + 32'(i) * 32'd4);
            cyc();
        end

        // Wait states: ack after three idle cycles.
        do_reset(32'h0000_1000);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("ws_req",  32'(imem_req), 32'd1);
            chk("ws_addr", imem_addr,     32'h1000);
            cyc();
        end
        chk("ws_req4",  32'(imem_req), 32'd1);
        chk("ws_addr4", imem_addr,     32'h1000);
        imem_ack = 1; imem_rdata = 32'hCAFE_0001;
        cyc();
        imem_ack = 0;
        chk("ws_data", inst_data, 32'hCAFE_0001);
        inst_ready = 1;
        cyc();
        inst_ready = 0;

        // Kill an outstanding request with a misaligned redirect.
        cyc();
        redirect_valid = 1; redirect_target = 32'h2002;
        cyc();
        redirect_valid = 0;
        cyc();
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 0;
        chk("kill_valid", 32'(inst_valid), 32'd0);
        chk("kill_addr",  imem_addr,       32'h2000);

        // Trap and redirect together while a word is presented.
        imem_ack = 1; imem_rdata = 32'h0BAD_F00D;
        cyc();
        imem_ack = 0;
        chk("tr_pre_valid", 32'(inst_valid), 32'd1);
        trap_valid = 1; trap_target = 32'h80;
        redirect_valid = 1; redirect_target = 32'h400;
        cyc();
        trap_valid = 0; redirect_valid = 0;
        chk("tr_valid", 32'(inst_valid), 32'd0);
        chk("tr_addr",  imem_addr,       32'h80);

        // PC wrap with halt raised during the first request.
        do_reset(32'hFFFF_FFFC);
        cyc();
        halt = 1;
        cyc();
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        cyc();
        imem_ack = 0;
        chk("wrap_pc",  pc_out,  32'h0);
        chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1;
        cyc();
        inst_ready = 0;
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("halt_noreq", 32'(imem_req), 32'd0);
        end
        halt = 0;
        cyc();
        chk("unhalt_req", 32'(imem_req), 32'd1);

        // Backpressure, then asynchronous reset mid-cycle.
        imem_ack = 1; imem_rdata = 32'h5A5A_A5A5;
        cyc();
        imem_ack = 0;
        held_data = inst_data;
        held_pc   = inst_pc;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_data",  inst_data,       held_data);
            chk("bp_pc",    inst_pc,         held_pc);
        end
        #3;
        rst = 0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_req",   32'(imem_req),   32'd0);
        chk("arst_pc",    pc_out,          32'd0);

        // Randomized traffic against the model.
        do_reset($urandom & 32'hFFFF_FFFC);
        for (int i = 0; i < 600; i++) begin
            redirect_valid  = ($urandom_range(0, 7) == 0);
            redirect_target = $urandom;
            trap_valid      = ($urandom_range(0, 11) == 0);
            trap_target     = $urandom;
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            inst_ready      = $urandom_range(0, 1) == 1;
            imem_ack        = m_req && ($urandom_range(0, 2) == 0);
            imem_rdata      = $urandom;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Sequences the instruction-fetch program counter for the RISC-V front end.
- Loads the boot address, steps the PC by a fixed increment, and applies branch/jump redirects and trap vectors with fixed priority.
- Runs a single-outstanding req/ack handshake to instruction memory and presents fetched words to the decoder through a valid/ready interface.
- Sits between the execute/trap logic and the instruction decoder.

Parameters:
- XLEN, 32: PC, address and target width.
- ILEN, 32: instruction word width.
- INC, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low; rst=0 forces reset state immediately.
- boot_addr  in  XLEN  initial PC, sampled once in BOOT.
- redirect_valid  in  1  branch/jump taken pulse.
- redirect_target  in  XLEN  branch/jump destination.
- trap_valid  in  1  trap/exception pulse.
- trap_target  in  XLEN  trap vector.
- halt  in  1  level; stop issuing new fetches.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; equals pc_out.
- imem_ack  in  1  memory response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  ILEN  fetched word.
- inst_valid  out  1  inst_data/inst_pc valid toward the decoder.
- inst_ready  in  1  decoder accepts the word.
- inst_data  out  ILEN  fetched instruction.
- inst_pc  out  XLEN  address of inst_data.
- pc_out  out  XLEN  current PC register.
- halted  out  1  high while in HALTED.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT; pc, inst_data, inst_pc, kill = 0.
  - imem_req, inst_valid, halted = 0.
  - Reset takes effect mid-transaction with no completion; any in-flight ack is ignored.
- Decoding: imem_req=(state==REQ), inst_valid=(state==VALID), halted=(state==HALTED).
- BOOT: first clk edge with rst=1 does pc<=boot_addr, then goes to HALTED if halt=1, else to REQ.
- REQ:
  - imem_req=1; imem_addr is held stable until the cycle imem_ack=1. imem_req is never dropped before ack.
  - On ack with kill=0 and no redirect/trap this cycle: inst_data<=imem_rdata, inst_pc<=pc, pc<=pc+INC, go to VALID.
  - On ack with kill=1: discard the word, kill<=0, stay in REQ and issue the new pc next cycle.
- VALID:
  - inst_valid=1; inst_data and inst_pc are held stable until inst_ready=1.
  - On inst_ready: go to HALTED if halt=1, else to REQ.
  - Fetch-to-fetch latency with zero-wait memory and inst_ready=1: 2 cycles per instruction (REQ, VALID).
- HALTED: no requests. When halt=0, go to REQ on the next edge.
- Redirect/trap, evaluated each cycle in states other than BOOT:
  - Priority: trap_valid > redirect_valid > sequential increment.
  - New pc = selected target with bits [1:0] forced to 0.
  - In REQ without ack the same cycle: pc update is deferred. The request stays stable, the target is latched into a pending register, and kill<=1. When ack arrives, the word is dropped and pc<=pending target.
  - In REQ with ack the same cycle: the word is dropped and pc<=target. Stay in REQ.
  - In VALID: inst_valid drops the next cycle (word flushed regardless of inst_ready), pc<=target, go to REQ, or to HALTED if halt=1.
  - In HALTED: pc<=target; stay HALTED.
  - Multiple redirects while kill=1: the latest pending target (by priority) wins.
- Arithmetic: pc+INC is modulo 2^XLEN, so 0xFFFFFFFC+4 wraps to 0x00000000. No overflow flag.
- halt assertion never aborts an outstanding request; it takes effect at the next REQ-issue decision point.

Test Plan:
- Sequential fetch: rst released with boot_addr=0x00001000, imem_ack same cycle as req, inst_ready=1. Required: imem_addr sequence 0x1000, 0x1004, 0x1008; inst_pc matches each.
- Wait states: ack delayed 3 cycles. Required: imem_req=1 and imem_addr=0x1000 stable for all 4 cycles; inst_data=imem_rdata from the ack cycle.
- Kill during outstanding request: redirect_valid with target 0x2002 in the 2nd wait cycle; ack returns 0xDEADBEEF. Required: inst_valid never asserted for that word; next imem_addr=0x2000.
- Simultaneous trap and redirect in VALID: trap_target=0x80, redirect_target=0x400. Required: inst_valid deasserts next cycle; next imem_addr=0x80.
- Wrap and halt: boot_addr=0xFFFFFFFC, with halt raised during the first request. Required: first fetch completes; pc_out=0x00000000; halted=1 after inst_ready; no imem_req until halt=0.
- Backpressure then reset: inst_ready=0 for 4 cycles. Required: inst_valid, inst_data and inst_pc stable throughout. Then rst=0 mid-cycle. Required: inst_valid, imem_req and pc_out go to 0 immediately, without waiting for a clock edge.
